// File: rtl/rv32m_pkg.sv
// Shared types, constants and opcode helpers for the RV32M multiply/divide unit.
package rv32m_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam logic [DATA_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [DATA_WIDTH-1:0] INT_MIN       = 32'h8000_0000;

  // Divide family occupies the upper half of the funct3 space.
  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  // Remainder ops (REM/REMU) are the divide ops with bit 1 set.
  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: radix-2 shift-add multiply step or
// restoring shift-subtract divide step over an {acc_hi, acc_lo} register pair.
//   multiply: acc_hi = partial product high, acc_lo = multiplier shifting out / product low
//   divide:   acc_hi = partial remainder,   acc_lo = dividend shifting out / quotient in
module muldiv_iter
  import rv32m_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  div_mode,
  input  logic [data_width-1:0] acc_hi,
  input  logic [data_width-1:0] acc_lo,
  input  logic [data_width-1:0] opnd,
  output logic [data_width-1:0] acc_hi_nxt,
  output logic [data_width-1:0] acc_lo_nxt
);

  logic [data_width:0] mul_sum;
  logic [data_width:0] rem_sh;
  logic [data_width:0] diff;

  // Single step; the carry bit of the add and the borrow bit of the subtract
  // are kept in the extra MSB so nothing is lost at full width.
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh     = {acc_hi, acc_lo[data_width-1]};
    diff       = rem_sh - {1'b0, opnd};
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    if (div_mode) begin
      if (!diff[data_width]) begin
        acc_hi_nxt = diff[data_width-1:0];
        acc_lo_nxt = {acc_lo[data_width-2:0], 1'b1};
      end else begin
        acc_hi_nxt = rem_sh[data_width-1:0];
        acc_lo_nxt = {acc_lo[data_width-2:0], 1'b0};
      end
    end else begin
      acc_hi_nxt = mul_sum[data_width:1];
      acc_lo_nxt = {mul_sum[0], acc_lo[data_width-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; special cases resolve straight to DONE
//   BUSY  | one shift-add / shift-subtract per edge, 32 iterations
//   DONE  | result_valid pulse, result held; always back to IDLE
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            MD_Control,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  input  logic                  flush,
  output logic [data_width-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  hold_pipeline
);

  md_state_e             state_q, state_d;
  md_op_e                op_q, op_d;
  logic [cnt_width-1:0]  count_q, count_d;
  logic [data_width-1:0] acc_hi_q, acc_hi_d;
  logic [data_width-1:0] acc_lo_q, acc_lo_d;
  logic [data_width-1:0] opnd_q, opnd_d;
  logic                  neg_a_q, neg_a_d;
  logic                  neg_b_q, neg_b_d;
  logic [data_width-1:0] result_q, result_d;
  logic                  result_valid_q, result_valid_d;

  md_op_e                op_in;
  logic                  a_neg, b_neg;
  logic [data_width-1:0] a_mag, b_mag;
  logic                  div_zero, div_ovf;
  logic [data_width-1:0] iter_hi, iter_lo;
  logic [2*data_width-1:0] prod, prod_s;
  logic [data_width-1:0] quot_s, rem_s;
  logic [data_width-1:0] final_res;

  assign op_in = md_op_e'(MD_Control);

  muldiv_iter #(.data_width(data_width)) u_iter (
    .div_mode   (is_div(op_q)),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .opnd       (opnd_q),
    .acc_hi_nxt (iter_hi),
    .acc_lo_nxt (iter_lo)
  );

  // Operand magnitudes and special-case detection for the request cycle.
  always_comb begin
    a_neg    = is_signed_a(op_in) & operand_A[data_width-1];
    b_neg    = is_signed_b(op_in) & operand_B[data_width-1];
    a_mag    = a_neg ? -operand_A : operand_A;
    b_mag    = b_neg ? -operand_B : operand_B;
    div_zero = is_div(op_in) && (operand_B == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (operand_A == INT_MIN) && (operand_B == '1);
  end

  // Sign correction and result select, fed by the final iteration's output so
  // the corrected value is captured on the same edge that enters DONE.
  always_comb begin
    prod      = {iter_hi, iter_lo};
    prod_s    = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot_s    = (neg_a_q ^ neg_b_q) ? -iter_lo : iter_lo;
    rem_s     = neg_a_q ? -iter_hi : iter_hi;
    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = prod_s[data_width-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*data_width-1:data_width];
      OP_DIV, OP_DIVU:              final_res = quot_s;
      default:                      final_res = rem_s;
    endcase
  end

  // Next-state and next-register computation for the controller.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    count_d        = count_q;
    acc_hi_d       = acc_hi_q;
    acc_lo_d       = acc_lo_q;
    opnd_d         = opnd_q;
    neg_a_d        = neg_a_q;
    neg_b_d        = neg_b_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d    = op_in;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          count_d = '0;
          if (div_zero) begin
            result_d       = is_rem(op_in) ? operand_A : DIV_BY_ZERO_Q;
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else if (div_ovf) begin
            result_d       = is_rem(op_in) ? '0 : INT_MIN;
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = is_div(op_in) ? a_mag : b_mag;
            opnd_d   = is_div(op_in) ? b_mag : a_mag;
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = iter_hi;
          acc_lo_d = iter_lo;
          count_d  = count_q + cnt_width'(1);
          if (count_q == cnt_width'(data_width - 1)) begin
            result_d       = final_res;
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_MUL;
      count_q        <= '0;
      acc_hi_q       <= '0;
      acc_lo_q       <= '0;
      opnd_q         <= '0;
      neg_a_q        <= 1'b0;
      neg_b_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      count_q        <= count_d;
      acc_hi_q       <= acc_hi_d;
      acc_lo_q       <= acc_lo_d;
      opnd_q         <= opnd_d;
      neg_a_q        <= neg_a_d;
      neg_b_q        <= neg_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Stall is released in DONE so EX/MEM captures the result on the same edge.
  always_comb begin
    result        = result_q;
    result_valid  = result_valid_q;
    busy          = (state_q != ST_IDLE);
    hold_pipeline = (state_q == ST_BUSY) | ((state_q == ST_IDLE) & start & ~flush);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors with literal results,
// an arithmetic reference model, and a per-cycle compare process.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  MD_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        flush;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        hold_pipeline;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] exp;
    int          s;
    int          due;
  } pend_t;
  pend_t q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  muldiv_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .MD_Control    (MD_Control),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .flush         (flush),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .hold_pipeline (hold_pipeline)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] p;
    logic [63:0] r;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = sa / sb;
        return r[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called at a falling edge: presents one request and returns at the next one.
  task automatic issue(input vec_t v);
    chk($sformatf("model op%0d", v.op), model(v.op, v.a, v.b), v.exp);
    start      = 1'b1;
    MD_Control = v.op;
    operand_A  = v.a;
    operand_B  = v.b;
    q.push_back('{exp: v.exp, s: cyc + 1, due: cyc + 1 + (is_special(v.op, v.a, v.b) ? 0 : 32)});
    @(negedge clk);
    start      = 1'b0;
    MD_Control = 3'($urandom_range(0, 7));
    operand_A  = $urandom;
    operand_B  = $urandom;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Per-cycle check of every output against the outstanding-request model.
  always begin
    bit in_op;
    bit exp_valid;
    bit exp_hold;
    @(negedge clk);
    #1;
    if (q.size() != 0 && cyc > q[0].due) begin
      chk("result_valid timeout", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    in_op     = (q.size() != 0) && cyc >= q[0].s && cyc <= q[0].due;
    exp_valid = (q.size() != 0) && cyc == q[0].due;
    exp_hold  = (in_op && cyc < q[0].due) || (!in_op && start && !flush);
    chk("result_valid", 32'(result_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(in_op));
    chk("hold_pipeline", 32'(hold_pipeline), 32'(exp_hold));
    if (!rst_n) chk("result in reset", result, 32'd0);
    if (exp_valid) begin
      chk("result", result, q[0].exp);
      void'(q.pop_front());
    end
  end

  vec_t vecs[$] = '{
    '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,       32'd7,         32'd14},
    '{3'd7, 32'd100,       32'd7,         32'd2},
    '{3'd1, 32'hFFFF_FFFB, 32'd7,         32'hFFFF_FFFF},
    '{3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2},
    '{3'd6, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE},
    '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0},
    '{3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1},
    '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,         32'd0,         32'd5},
    '{3'd7, 32'd7,         32'd0,         32'd7},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
  };

  initial begin
    vec_t v;
    rst_n      = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    MD_Control = 3'd0;
    operand_A  = '0;
    operand_B  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_empty();
    end

    // Flush ten iterations into a divide: no result, then a fresh op completes.
    v = '{3'd5, 32'd1000, 32'd7, 32'd142};
    issue(v);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(q.pop_front());
    repeat (3) @(negedge clk);
    v = '{3'd5, 32'd9, 32'd3, 32'd3};
    issue(v);
    wait_empty();

    // flush together with start in IDLE: request dropped.
    start = 1'b1; flush = 1'b1; MD_Control = 3'd0; operand_A = 32'd3; operand_B = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset twenty iterations into a multiply.
    v = '{3'd0, 32'd1234, 32'd5678, 32'd7006652};
    issue(v);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #2;
    chk("async rst result", result, 32'd0);
    chk("async rst valid", 32'(result_valid), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst hold", 32'(hold_pipeline), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start during BUSY is ignored: original multiply result stands.
    v = '{3'd0, 32'd12345, 32'd678, 32'd8369910};
    issue(v);
    repeat (5) @(negedge clk);
    start = 1'b1; MD_Control = 3'd5; operand_A = 32'd50; operand_B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, in parallel with the ALU.
- Fed by the same ID/EX operand bus (rs1/rs2 values) plus the funct3 of M-type instructions.
- Holds the pipeline while it computes.
- Its result is muxed with ALU_result into the EX/MEM register when result_valid is high.

Parameters:
data_width, 32, operand/result width; only 32 supported.
cnt_width, 6, iteration counter width; must satisfy 2^cnt_width > data_width.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; op/operands valid this cycle.
MD_Control  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
operand_A  input  data_width  rs1 value (dividend / multiplicand).
operand_B  input  data_width  rs2 value (divisor / multiplier).
flush  input  1  kill in-flight op (branch/JALR redirect).
result  output  data_width  final result, valid only with result_valid.
result_valid  output  1  one-cycle pulse, result ready.
busy  output  1  state != IDLE.
hold_pipeline  output  1  stall request to hazard unit.

Behaviour:
- Reset: clock is clk; reset is asynchronous active-low (rst_n). On reset: state=IDLE, result=0, result_valid=0, busy=0, hold_pipeline=0, all internal registers 0. Reset mid-operation abandons the op; no result_valid.
- States: IDLE, BUSY, DONE.
- IDLE: start=1 at edge E0 latches op and operands.
  - Special cases go IDLE->DONE directly (latency 1).
  - Otherwise IDLE->BUSY with count=0; magnitudes taken per signedness: MULH/DIV/REM signed both; MULHSU signed A only; others unsigned.
- BUSY: one iteration per edge.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder plus quotient.
  - After the edge where count reaches data_width-1 (edge E32): ->DONE.
  - Sign correction applied on the DONE transition.
    - Product: negate the 64-bit value if signs differ.
    - Quotient: negate if signs differ.
    - Remainder: takes the dividend's sign.
- DONE: result_valid=1 for exactly one cycle, result stable. Next edge ->IDLE.
  - start is ignored in DONE; the hazard unit re-presents it after the EX/MEM advance.
  - Normal latency: start edge E0, result_valid high in the cycle after E32 (33 cycles).
- Result select:
  - MUL -> product[31:0].
  - MULH/MULHSU/MULHU -> product[63:32].
  - DIV/DIVU -> quotient.
  - REM/REMU -> remainder.
- Special cases (1-cycle):
  - Divisor 0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> operand_A.
  - Signed overflow (A=32'h80000000, B=-1): DIV -> 32'h80000000; REM -> 0.
- hold_pipeline = (state==BUSY) | (state==IDLE & start & ~flush).
  - Deasserted in DONE so the pipeline advances on the same edge the result is captured.
- busy = (state != IDLE).
- flush:
  - In BUSY: ->IDLE next edge, no result_valid.
  - In DONE: result_valid still pulses; the EX/MEM flush discards it.
  - Simultaneous with start in IDLE: start ignored.
- start while BUSY: ignored; operands are not re-latched.
- Operand inputs are don't-care after E0.
- All arithmetic is unsigned on magnitudes. Negation is two's complement at full width (64-bit for product).

Decomposition:
- Package rv32m_pkg:
  - md_op_e enum (8 funct3 codes).
  - md_state_e enum (IDLE, BUSY, DONE).
  - Constants DIV_BY_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
  - Helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- Sub-module muldiv_iter: combinational single-step datapath (one shift-add or one shift-subtract).
- muldiv_unit owns the FSM, counter, operand/sign registers and final result select.

Test Plan:
- MUL, A=7, B=-3: result_valid 33 cycles after start, result=32'hFFFFFFEB; hold_pipeline high 33 cycles then low in DONE.
- MULH A=32'h80000000 B=32'h80000000 -> 32'h40000000. MULHU A=B=32'hFFFFFFFF -> 32'hFFFFFFFE. MULHSU A=-1 B=32'hFFFFFFFF -> 32'hFFFFFFFF.
- DIV A=-7 B=2 -> 32'hFFFFFFFD. REM same operands -> 32'hFFFFFFFF. DIVU A=100 B=7 -> 14. REMU same operands -> 2.
- DIVU A=5 B=0 -> 32'hFFFFFFFF; REM A=5 B=0 -> 5; DIV A=32'h80000000 B=-1 -> 32'h80000000. All special cases: result_valid one cycle after start, hold_pipeline only in the start cycle.
- flush asserted at BUSY count 10 -> IDLE next cycle, no result_valid. A new start afterwards (DIVU 9/3) -> 3.
- rst_n low at BUSY count 20 -> all outputs 0 immediately, without a clock edge. A start pulse during BUSY of a MUL is ignored: original result unchanged.
